dm_be_ctrl: RTL and testbench

Parametrised successor to the word-only data memory. Byte-addressed single-port RAM with byte, halfword and word stores, and sign- or zero-extended loads. The async bulk clear is replaced by a sequential clear sweep, one word per cycle, which can also be requested at run time. Sits between the execute-stage address/data path and writeback; misaligned or illegal accesses are flagged and never corrupt memory.

---
 rtl/dm_pkg.sv | 52 +++++
 rtl/dm_ld_ext.sv | 39 +++
 rtl/dm_be_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_dm_be_ctrl.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the byte-enabled data memory (dm_be_ctrl):
//   - funct3-style access mode codes
//   - controller FSM state encoding
//   - be_of():          byte-enable mask of a store
//   - is_misaligned():  alignment / legality check for an access
// ---------------------------------------------------------------------------
package dm_pkg;

    // Access modes (funct3 encoding). Codes 011, 110 and 111 are illegal.
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dm_state_e;

    // Byte-enable mask for a store of the given mode at lane addr_lo.
    // The unsigned byte/half codes select the same lanes as their signed
    // counterparts; illegal codes enable nothing.
    function automatic logic [3:0] be_of(input logic [2:0] mode,
                                         input logic [1:0] addr_lo);
        logic [3:0] be;
        case (mode)
            MODE_B, MODE_BU: be = 4'b0001 << addr_lo;
            MODE_H, MODE_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            MODE_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    // High when the access is misaligned for its size or the mode is illegal.
    function automatic logic is_misaligned(input logic [2:0] mode,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (mode)
            MODE_B, MODE_BU: mis = 1'b0;
            MODE_H, MODE_HU: mis = addr_lo[0];
            MODE_W:          mis = (addr_lo != 2'b00);
            default:         mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_ld_ext.sv
// ---------------------------------------------------------------------------
// dm_ld_ext
// Combinational load formatter: picks the addressed byte / halfword out of
// the 32-bit memory word and sign- or zero-extends it according to mode.
// Ports:
//   word     in  32  memory word holding the addressed data
//   mode     in  3   access mode (MODE_B .. MODE_HU)
//   addr_lo  in  2   byte lane within the word
//   dout     out 32  extended load data (0 for illegal modes)
// Alignment is not checked here; the caller masks misaligned results.
// ---------------------------------------------------------------------------
module dm_ld_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    output logic [31:0] dout
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        // Halfwords are only legal on even lanes, so addr_lo[1] picks the half.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (mode)
            MODE_B:  dout = {{24{byte_sel[7]}}, byte_sel};
            MODE_BU: dout = {24'h000000, byte_sel};
            MODE_H:  dout = {{16{half_sel[15]}}, half_sel};
            MODE_HU: dout = {16'h0000, half_sel};
            MODE_W:  dout = word;
            default: dout = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_be_ctrl.sv
// ---------------------------------------------------------------------------
// dm_be_ctrl
// Byte-addressed single-port data memory with byte/half/word stores,
// sign/zero-extended loads and a sequential clear sweep (one word per cycle).
// Ports:
//   clk       in  1         rising-edge clock
//   rst       in  1         asynchronous active-high reset
//   addr      in  ADDR_W+2  byte address ([ADDR_W+1:2] word, [1:0] lane)
//   din       in  DATA_W    right-aligned store data
//   we        in  1         store request
//   mode      in  3         access mode (see dm_pkg)
//   clr_req   in  1         pulse: start a clear sweep from IDLE
//   dout      out DATA_W    combinational, extended load data
//   busy      out 1         clear sweep in progress
//   misalign  out 1         current access is misaligned or mode illegal
//   err       out 1         sticky: a store was rejected since reset
// Memory is held as four byte-lane arrays so each lane has its own write
// enable; reads are asynchronous so dout follows addr within the cycle and
// a read in the cycle of a write still sees the old word.
// ---------------------------------------------------------------------------
module dm_be_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W+1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic [2:0]        mode,
    input  logic              clr_req,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              misalign,
    output logic              err
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NLANES = DATA_W / 8;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    dm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              err_q, err_d;

    // ---------------------------------------------------------------------
    // Address decode and access checks
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        addr_lo;
    logic              mis;
    logic              in_clear;

    assign word_addr = addr[ADDR_W+1:2];
    assign addr_lo   = addr[1:0];
    assign mis       = is_misaligned(mode, addr_lo);
    assign in_clear  = (state_q == ST_CLEAR);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
            clr_ptr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            err_q     <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                // A rejected store latches the error until reset.
                if (we && mis) begin
                    err_d = 1'b1;
                end
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end

            ST_CLEAR: begin
                // clr_req is deliberately not looked at: a sweep cannot be
                // restarted except by reset.
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (&clr_ptr_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Write port: either the clear sweep or a store from the datapath
    // ---------------------------------------------------------------------
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_be;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = word_addr;
        wr_be   = be_of(mode, addr_lo);

        // Store data is replicated into every lane; the byte enables decide
        // which lanes actually take it.
        case (mode)
            MODE_B, MODE_BU: wr_data = {4{din[7:0]}};
            MODE_H, MODE_HU: wr_data = {2{din[15:0]}};
            default:         wr_data = din;
        endcase

        if (in_clear) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr_q;
            wr_be   = 4'b1111;
            wr_data = '0;
        end else begin
            wr_en = we && !mis;
        end

        // No writes while reset is held, so an interrupted sweep or a stray
        // store cannot touch memory during reset.
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Memory: one byte-wide array per lane
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_addr];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] ext_word;

    dm_ld_ext u_ld_ext (
        .word    (rd_word),
        .mode    (mode),
        .addr_lo (addr_lo),
        .dout    (ext_word)
    );

    // Load data is forced to zero during a sweep and for bad accesses.
    assign dout     = (in_clear || mis) ? '0 : ext_word;
    assign busy     = in_clear;
    assign misalign = mis;
    assign err      = err_q;

endmodule

// File: tb/tb_dm_be_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_be_ctrl
// Self-checking bench for dm_be_ctrl. The reference model is a flat byte
// array (little-endian); loads and stores are computed from access size and
// byte address rather than from lanes and enables.
// ---------------------------------------------------------------------------
module tb_dm_be_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DEPTH * 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       din;
    logic              we;
    logic [2:0]        mode;
    logic              clr_req;
    logic [31:0]       dout;
    logic              busy;
    logic              misalign;
    logic              err;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [7:0] ref_mem [NBYTES];
    bit         ref_err;

    dm_be_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (32),
        .CLR_ON_RST (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .din      (din),
        .we       (we),
        .mode     (mode),
        .clr_req  (clr_req),
        .dout     (dout),
        .busy     (busy),
        .misalign (misalign),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic int size_of(input logic [2:0] m);
        case (m)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [2:0] m, input int a);
        int sz;
        sz = size_of(m);
        return (sz == 0) || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] m, input int a);
        logic [31:0] v;
        int sz;
        if (ref_mis(m, a)) return 32'h0;
        sz = size_of(m);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (m == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (m == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] m, input int a, input logic [31:0] d);
        int sz;
        sz = size_of(m);
        for (int i = 0; i < sz; i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    task automatic ref_clear();
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    endtask

    // ---------------------------------------------------------------------
    // Drive helpers (no checking)
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input int a, input logic [31:0] d,
                         input logic w);
        mode = m;
        addr = (ADDR_W+2)'(a);
        din  = d;
        we   = w;
    endtask

    // Waits while busy, counting edges; returns the count (bounded).
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            step();
            n++;
        end
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int n;
        logic [2:0] m;
        int a;
        drive(3'b010, 0, 32'h0, 1'b0);
        clr_req = 1'b0;
        rst     = 1'b1;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b required 1", busy);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: err=%b required 0", err);
        end
        rst = 1'b0;
        ref_clear();
        ref_err = 1'b0;
        // Sweep with random store traffic that must be ignored.
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            m = 3'($urandom_range(0, 7));
            a = int'($urandom_range(0, NBYTES - 1));
            drive(m, a, $urandom(), 1'($urandom_range(0, 1)));
            #1;
            n_checks++;
            if (dout !== 32'h0) begin
                n_fail++;
                $display("FAIL sweep_dout: dout=%h required 00000000", dout);
            end
            n_checks++;
            if (misalign !== ref_mis(m, a)) begin
                n_fail++;
                $display("FAIL sweep_misalign: misalign=%b required %b (mode=%b addr=%h)",
                         misalign, ref_mis(m, a), m, a);
            end
            step();
            n++;
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_err: err=%b required 0", err);
            end
        end
        we = 1'b0;
        n_checks++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL reset_sweep_len: busy cycles=%0d required %0d", n, DEPTH);
        end
        $display("reset sweep: busy for %0d cycles", n);
        // Every word must now read zero.
        for (int w = 0; w < DEPTH; w++) begin
            drive(3'b010, w * 4, 32'h0, 1'b0);
            #1;
            n_checks++;
            if (dout !== 32'h0) begin
                n_fail++;
                $display("FAIL clear_word: word %0d dout=%h required 00000000", w, dout);
            end
        end
    endtask

    task automatic test_byte_half_stores();
        drive(3'b010, 'h10, 32'h1122_3344, 1'b1); step(); ref_store(3'b010, 'h10, 32'h1122_3344);
        $display("SW 11223344 @010");
        drive(3'b000, 'h12, 32'h0000_00AA, 1'b1); step(); ref_store(3'b000, 'h12, 32'h0000_00AA);
        $display("SB aa @012");
        drive(3'b001, 'h10, 32'h0000_BEEF, 1'b1); step(); ref_store(3'b001, 'h10, 32'h0000_BEEF);
        $display("SH beef @010");
        drive(3'b010, 'h10, 32'h0, 1'b0);
        #1;
        $display("LW @010 -> %h", dout);
        n_checks++;
        if (dout !== 32'h11AA_BEEF) begin
            n_fail++;
            $display("FAIL bh_store_lw: dout=%h required 11aabeef", dout);
        end
        drive(3'b100, 'h12, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== 32'h0000_00AA) begin
            n_fail++;
            $display("FAIL bh_store_lbu: dout=%h required 000000aa", dout);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  ms [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        int          as [4] = '{'h23, 'h23, 'h22, 'h20};
        logic [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        drive(3'b010, 'h20, 32'h80FF_7F01, 1'b1); step(); ref_store(3'b010, 'h20, 32'h80FF_7F01);
        we = 1'b0;
        $display("SW 80ff7f01 @020");
        for (int i = 0; i < 4; i++) begin
            drive(ms[i], as[i], 32'h0, 1'b0);
            #1;
            $display("load mode=%b @%h -> %h", ms[i], as[i], dout);
            n_checks++;
            if (dout !== ex[i]) begin
                n_fail++;
                $display("FAIL load_ext_%0d: dout=%h required %h", i, dout, ex[i]);
            end
        end
    endtask

    task automatic test_illegal_mode();
        logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err_pre: err=%b required 0", err);
        end
        for (int i = 0; i < 3; i++) begin
            drive(bad[i], 'h20, 32'h0, 1'b0);
            #1;
            n_checks++;
            if (misalign !== 1'b1 || dout !== 32'h0) begin
                n_fail++;
                $display("FAIL illegal_load: mode=%b misalign=%b dout=%h required 1 / 00000000",
                         bad[i], misalign, dout);
            end
        end
        drive(3'b011, 0, 32'hCAFE_F00D, 1'b1);
        #1;
        step();
        we = 1'b0;
        ref_err = 1'b1;
        $display("store mode=011 @000 rejected, err=%b", err);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err: err=%b required 1", err);
        end
        drive(3'b010, 0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== ref_load(3'b010, 0)) begin
            n_fail++;
            $display("FAIL illegal_nowrite: dout=%h required %h", dout, ref_load(3'b010, 0));
        end
    endtask

    task automatic test_misalign();
        int n;
        // Reset to clear the sticky error, then re-seed the test word.
        drive(3'b010, 0, 32'h0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_sweep(n);
        ref_clear();
        ref_err = 1'b0;
        n_checks++;
        if (n != DEPTH || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_reset: busy cycles=%0d err=%b required %0d / 0", n, err, DEPTH);
        end
        drive(3'b010, 'h20, 32'h80FF_7F01, 1'b1); step(); ref_store(3'b010, 'h20, 32'h80FF_7F01);
        drive(3'b010, 'h21, 32'hDEAD_BEEF, 1'b1);
        #1;
        n_checks++;
        if (misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_flag: misalign=%b required 1", misalign);
        end
        step();
        we = 1'b0;
        ref_err = 1'b1;
        $display("SW deadbeef @021 rejected, err=%b", err);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_err: err=%b required 1", err);
        end
        drive(3'b010, 'h20, 32'h0, 1'b0);
        repeat (10) step();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_err_sticky: err=%b required 1", err);
        end
        n_checks++;
        if (dout !== 32'h80FF_7F01) begin
            n_fail++;
            $display("FAIL mis_nowrite: dout=%h required 80ff7f01", dout);
        end
        drive(3'b010, 'h24, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++;
            $display("FAIL mis_nowrite_next: dout=%h required 00000000", dout);
        end
        drive(3'b001, 'h21, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== 32'h0 || misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_lh: dout=%h misalign=%b required 00000000 / 1", dout, misalign);
        end
    endtask

    task automatic test_clr_req();
        int n;
        logic [31:0] v;
        v = $urandom() | 32'h1;
        drive(3'b010, 'h40, v, 1'b1); step(); ref_store(3'b010, 'h40, v);
        we = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_busy: busy=%b required 1", busy);
        end
        // A second request mid-sweep must not stretch the sweep.
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            clr_req = (n == 200);
            step();
            n++;
        end
        clr_req = 1'b0;
        ref_clear();
        $display("clr_req sweep: busy for %0d cycles", n);
        n_checks++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL clr_sweep_len: busy cycles=%0d required %0d", n, DEPTH);
        end
        n_checks++;
        if (err !== ref_err) begin
            n_fail++;
            $display("FAIL clr_err_kept: err=%b required %b", err, ref_err);
        end
        drive(3'b010, 'h40, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_word: dout=%h required 00000000", dout);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        logic [31:0] v;
        v = $urandom() | 32'h1;
        drive(3'b010, 'h7FC, v, 1'b1); step();
        we = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (500) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_busy: busy=%b required 1", busy);
        end
        step();
        rst = 1'b0;
        ref_clear();
        ref_err = 1'b0;
        wait_sweep(n);
        $display("mid-sweep reset: busy for %0d cycles after rst", n);
        n_checks++;
        if (n != DEPTH) begin
            n_fail++;
            $display("FAIL mid_rst_len: busy cycles=%0d required %0d", n, DEPTH);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_err: err=%b required 0", err);
        end
        drive(3'b010, 'h7FC, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (dout !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst_word: dout=%h required 00000000", dout);
        end
    endtask

    task automatic test_random();
        logic [2:0]  m;
        int          a;
        logic [31:0] d;
        logic        w;
        logic [31:0] exp_d;
        for (int i = 0; i < 400; i++) begin
            m = 3'($urandom_range(0, 7));
            a = int'($urandom_range(0, 255));
            d = $urandom();
            w = 1'($urandom_range(0, 1));
            drive(m, a, d, w);
            #1;
            exp_d = ref_load(m, a);
            $display("rand %0d: mode=%b addr=%h we=%b din=%h dout=%h", i, m, a, w, d, dout);
            n_checks++;
            if (misalign !== ref_mis(m, a)) begin
                n_fail++;
                $display("FAIL rand_misalign: misalign=%b required %b", misalign, ref_mis(m, a));
            end
            n_checks++;
            if (dout !== exp_d) begin
                n_fail++;
                $display("FAIL rand_dout: dout=%h required %h", dout, exp_d);
            end
            step();
            if (w) begin
                if (ref_mis(m, a)) ref_err = 1'b1;
                else               ref_store(m, a, d);
            end
            n_checks++;
            if (err !== ref_err) begin
                n_fail++;
                $display("FAIL rand_err: err=%b required %b", err, ref_err);
            end
        end
        we = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Sequencer and watchdog
    // ---------------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        we       = 1'b0;
        clr_req  = 1'b0;
        mode     = 3'b010;
        addr     = '0;
        din      = '0;
        test_reset();
        test_byte_half_stores();
        test_load_ext();
        test_illegal_mode();
        test_misalign();
        test_clr_req();
        test_mid_sweep_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
